// File: rtl/term_esc_decoder.sv
// term_esc_decoder
//   Host-side byte decoder for the terminal. Consumes the UART RX byte stream
//   and turns it into text-buffer writes and cursor motion. Printable bytes are
//   written at the cursor, CR/LF/BS move the cursor, and ANSI CSI sequences
//   (ESC [ p1 ; p2 final) provide absolute/relative cursor moves and a full
//   clear-screen that sweeps 0x20 across every cell.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   i_byte     received byte
//   i_byte_v   one-cycle strobe qualifying i_byte
//   o_ready    high while bytes are accepted (low only while clearing)
//   o_overrun  one-cycle pulse: a byte arrived while o_ready was low (dropped)
//   o_wen      text buffer write enable, one-cycle pulse per write
//   o_addr     text buffer address (row*COLS+col)
//   o_wdata    text buffer write data
//   o_cursor   current cursor address (row*COLS+col)
module term_esc_decoder #(
    parameter int COLS = 40,
    parameter int ROWS = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_byte,
    input  logic       i_byte_v,
    output logic       o_ready,
    output logic       o_overrun,
    output logic       o_wen,
    output logic [9:0] o_addr,
    output logic [7:0] o_wdata,
    output logic [9:0] o_cursor
);

    localparam int CELLS = COLS * ROWS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {ST_GROUND, ST_ESC, ST_CSI, ST_CLEAR} state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic [7:0]     p1_q, p1_d, p2_q, p2_d;
    logic           pidx_q, pidx_d;
    logic [10:0]    clr_q, clr_d;
    logic           wen_q, wen_d;
    logic [9:0]     addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [9:0]     cursor_q, cursor_d;
    logic           ready_q, ready_d;
    logic           overrun_q, overrun_d;

    // Cursor arithmetic is done on 11-bit operands so that "row - n" and
    // "col + n" can be compared against the screen edges without wrapping.
    logic [10:0] row_w, col_w, n1, n2;
    logic [10:0] home_row, home_col, up_row, dn_row, rt_col, lf_col;
    logic [7:0]  pcur, psat;
    logic [11:0] pacc;
    logic        is_digit, is_print;

    assign row_w = 11'(row_q);
    assign col_w = 11'(col_q);
    // A parameter of 0 (or omitted) means 1.
    assign n1 = (p1_q == 8'd0) ? 11'd1 : {3'd0, p1_q};
    assign n2 = (p2_q == 8'd0) ? 11'd1 : {3'd0, p2_q};

    assign home_row = (n1 > 11'(ROWS)) ? 11'(ROWS - 1) : n1 - 11'd1;
    assign home_col = (n2 > 11'(COLS)) ? 11'(COLS - 1) : n2 - 11'd1;
    assign up_row   = (row_w > n1) ? row_w - n1 : 11'd0;
    assign dn_row   = (row_w + n1 > 11'(ROWS - 1)) ? 11'(ROWS - 1) : row_w + n1;
    assign lf_col   = (col_w > n1) ? col_w - n1 : 11'd0;
    assign rt_col   = (col_w + n1 > 11'(COLS - 1)) ? 11'(COLS - 1) : col_w + n1;

    // Decimal accumulation into the currently selected parameter, saturating at 255.
    assign is_digit = (i_byte >= 8'h30) && (i_byte <= 8'h39);
    assign is_print = (i_byte >= 8'h20) && (i_byte <= 8'h7E);
    assign pcur     = pidx_q ? p2_q : p1_q;
    assign pacc     = 12'(pcur) * 12'd10 + {8'd0, i_byte[3:0]};
    assign psat     = (pacc > 12'd255) ? 8'hFF : pacc[7:0];

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        pidx_d    = pidx_q;
        clr_d     = clr_q;
        wen_d     = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ready_d   = ready_q;
        overrun_d = i_byte_v && (state_q == ST_CLEAR);

        case (state_q)
            ST_GROUND: begin
                if (i_byte_v) begin
                    if (is_print) begin
                        wen_d   = 1'b1;
                        addr_d  = cursor_q;
                        wdata_d = i_byte;
                        if (col_q == CW'(COLS - 1)) begin
                            col_d = '0;
                            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else if (i_byte == 8'h0D) begin
                        col_d = '0;
                    end else if (i_byte == 8'h0A) begin
                        row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                    end else if (i_byte == 8'h08) begin
                        if (col_q != '0) col_d = col_q - CW'(1);
                    end else if (i_byte == 8'h1B) begin
                        state_d = ST_ESC;
                    end
                end
            end

            ST_ESC: begin
                if (i_byte_v) begin
                    if (i_byte == 8'h5B) begin
                        state_d = ST_CSI;
                        p1_d    = '0;
                        p2_d    = '0;
                        pidx_d  = 1'b0;
                    end else begin
                        state_d = ST_GROUND;
                    end
                end
            end

            ST_CSI: begin
                if (i_byte_v) begin
                    if (is_digit) begin
                        if (pidx_q) p2_d = psat;
                        else        p1_d = psat;
                    end else if (i_byte == 8'h3B) begin
                        pidx_d = 1'b1;
                    end else if (i_byte == 8'h1B) begin
                        state_d = ST_ESC;
                    end else if ((i_byte >= 8'h40) && (i_byte <= 8'h7E)) begin
                        state_d = ST_GROUND;
                        case (i_byte)
                            8'h48, 8'h66: begin
                                row_d = RW'(home_row);
                                col_d = CW'(home_col);
                            end
                            8'h41: row_d = RW'(up_row);
                            8'h42: row_d = RW'(dn_row);
                            8'h43: col_d = CW'(rt_col);
                            8'h44: col_d = CW'(lf_col);
                            8'h4A: begin
                                // The first clear write goes out with the 'J' itself so
                                // o_ready is already low when address 0 is written.
                                if (p1_q == 8'd2) begin
                                    state_d = ST_CLEAR;
                                    ready_d = 1'b0;
                                    wen_d   = 1'b1;
                                    addr_d  = '0;
                                    wdata_d = 8'h20;
                                    clr_d   = 11'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            ST_CLEAR: begin
                if (clr_q < 11'(CELLS)) begin
                    wen_d   = 1'b1;
                    addr_d  = clr_q[9:0];
                    wdata_d = 8'h20;
                    clr_d   = clr_q + 11'd1;
                end else begin
                    state_d = ST_GROUND;
                    row_d   = '0;
                    col_d   = '0;
                    ready_d = 1'b1;
                end
            end

            default: state_d = ST_GROUND;
        endcase

        cursor_d = 10'(int'(row_d) * COLS + int'(col_d));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_GROUND;
            row_q     <= '0;
            col_q     <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            pidx_q    <= 1'b0;
            clr_q     <= '0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cursor_q  <= '0;
            ready_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            pidx_q    <= pidx_d;
            clr_q     <= clr_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cursor_q  <= cursor_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_overrun = overrun_q;
    assign o_wen     = wen_q;
    assign o_addr    = addr_q;
    assign o_wdata   = wdata_q;
    assign o_cursor  = cursor_q;

endmodule
